// File: rtl/csr_file.sv
// Machine-mode CSR storage: architectural CSR state, the counters and the heap-bound registers.
// Reads come from committed state only; forwarding of in-flight values happens upstream.
module csr_file #(
  parameter int XLEN   = 64,
  parameter int HEAP_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       csr_raddr_i,
  output logic [XLEN-1:0]   csr_rdata_o,
  output logic              csr_illegal_o,
  input  logic [11:0]       wb_csraddr_i,
  input  logic [XLEN-1:0]   wb_csrdata_i,
  input  logic              wb_csrwe_i,
  input  logic [11:0]       heap_csraddr_i,
  input  logic [HEAP_W-1:0] heap_csrdata_i,
  input  logic              heap_csrwe_i,
  input  logic              trap_i,
  input  logic [XLEN-1:0]   trap_epc_i,
  input  logic [XLEN-1:0]   trap_cause_i,
  input  logic              mret_i,
  input  logic              retire_i,
  output logic [XLEN-1:0]   mtvec_o,
  output logic [XLEN-1:0]   mepc_o,
  output logic              mie_o,
  output logic [XLEN-1:0]   heap_base_o,
  output logic [XLEN-1:0]   heap_limit_o,
  output logic              heap_ovf_o
);

  localparam logic [11:0] ADDR_MSTATUS    = 12'h300;
  localparam logic [11:0] ADDR_MTVEC      = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH   = 12'h340;
  localparam logic [11:0] ADDR_MEPC       = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE     = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE     = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET   = 12'hB02;
  localparam logic [11:0] ADDR_HEAP_BASE  = 12'h7C0;
  localparam logic [11:0] ADDR_HEAP_TOP   = 12'h7C1;
  localparam logic [11:0] ADDR_HEAP_LIMIT = 12'h7C2;

  localparam logic [XLEN-1:0] MASK_MTVEC = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] MASK_MEPC  = {{(XLEN-1){1'b1}}, 1'b0};

  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;
  logic [XLEN-1:0] heap_base_q, heap_base_d;
  logic [XLEN-1:0] heap_top_q, heap_top_d;
  logic [XLEN-1:0] heap_limit_q, heap_limit_d;
  logic            heap_ovf_q, heap_ovf_d;

  logic            top_wr, limit_wr, wb_top_wr;

  // Index 0 is the heap port, index 1 writeback; applying them in that order gives wb priority.
  logic [11:0]     w_addr [2];
  logic [XLEN-1:0] w_data [2];
  logic            w_we   [2];

  assign w_addr[0] = heap_csraddr_i;
  assign w_data[0] = {{(XLEN-HEAP_W){1'b0}}, heap_csrdata_i};
  assign w_we[0]   = heap_csrwe_i;
  assign w_addr[1] = wb_csraddr_i;
  assign w_data[1] = wb_csrdata_i;
  assign w_we[1]   = wb_csrwe_i;

  always_comb begin
    mie_d        = mie_q;
    mpie_d       = mpie_q;
    mtvec_d      = mtvec_q;
    mscratch_d   = mscratch_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;
    mcycle_d     = mcycle_q + XLEN'(1);
    minstret_d   = retire_i ? minstret_q + XLEN'(1) : minstret_q;
    heap_base_d  = heap_base_q;
    heap_top_d   = heap_top_q;
    heap_limit_d = heap_limit_q;
    heap_ovf_d   = heap_ovf_q;
    top_wr       = 1'b0;
    limit_wr     = 1'b0;
    wb_top_wr    = 1'b0;

    for (int s = 0; s < 2; s++) begin
      if (w_we[s]) begin
        case (w_addr[s])
          ADDR_MSTATUS: begin
            mie_d  = w_data[s][3];
            mpie_d = w_data[s][7];
          end
          ADDR_MTVEC:      mtvec_d    = w_data[s] & MASK_MTVEC;
          ADDR_MSCRATCH:   mscratch_d = w_data[s];
          ADDR_MEPC:       mepc_d     = w_data[s] & MASK_MEPC;
          ADDR_MCAUSE:     mcause_d   = w_data[s];
          ADDR_MCYCLE:     mcycle_d   = w_data[s];
          ADDR_MINSTRET:   minstret_d = w_data[s];
          ADDR_HEAP_BASE:  heap_base_d = w_data[s];
          ADDR_HEAP_TOP: begin
            heap_top_d = w_data[s];
            top_wr     = 1'b1;
            wb_top_wr  = (s == 1);
          end
          ADDR_HEAP_LIMIT: begin
            heap_limit_d = w_data[s];
            limit_wr     = 1'b1;
          end
          default: ;
        endcase
      end
    end

    if (trap_i) begin
      mepc_d   = trap_epc_i & MASK_MEPC;
      mcause_d = trap_cause_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end

    // Overflow is judged on the values the registers will hold after this edge.
    if ((top_wr || limit_wr) && (heap_top_d > heap_limit_d)) begin
      heap_ovf_d = 1'b1;
    end else if (wb_top_wr) begin
      heap_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q        <= 1'b0;
      mpie_q       <= 1'b0;
      mtvec_q      <= '0;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mcycle_q     <= '0;
      minstret_q   <= '0;
      heap_base_q  <= '0;
      heap_top_q   <= '0;
      heap_limit_q <= '0;
      heap_ovf_q   <= 1'b0;
    end else begin
      mie_q        <= mie_d;
      mpie_q       <= mpie_d;
      mtvec_q      <= mtvec_d;
      mscratch_q   <= mscratch_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
      mcycle_q     <= mcycle_d;
      minstret_q   <= minstret_d;
      heap_base_q  <= heap_base_d;
      heap_top_q   <= heap_top_d;
      heap_limit_q <= heap_limit_d;
      heap_ovf_q   <= heap_ovf_d;
    end
  end

  always_comb begin
    csr_rdata_o   = '0;
    csr_illegal_o = 1'b0;
    case (csr_raddr_i)
      ADDR_MSTATUS: begin
        csr_rdata_o[3] = mie_q;
        csr_rdata_o[7] = mpie_q;
      end
      ADDR_MTVEC:      csr_rdata_o = mtvec_q;
      ADDR_MSCRATCH:   csr_rdata_o = mscratch_q;
      ADDR_MEPC:       csr_rdata_o = mepc_q;
      ADDR_MCAUSE:     csr_rdata_o = mcause_q;
      ADDR_MCYCLE:     csr_rdata_o = mcycle_q;
      ADDR_MINSTRET:   csr_rdata_o = minstret_q;
      ADDR_HEAP_BASE:  csr_rdata_o = heap_base_q;
      ADDR_HEAP_TOP:   csr_rdata_o = heap_top_q;
      ADDR_HEAP_LIMIT: csr_rdata_o = heap_limit_q;
      default:         csr_illegal_o = 1'b1;
    endcase
  end

  assign mtvec_o      = mtvec_q;
  assign mepc_o       = mepc_q;
  assign mie_o        = mie_q;
  assign heap_base_o  = heap_base_q;
  assign heap_limit_o = heap_limit_q;
  assign heap_ovf_o   = heap_ovf_q;

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;
  localparam int XLEN   = 64;
  localparam int HEAP_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [11:0]       csr_raddr_i;
  logic [XLEN-1:0]   csr_rdata_o;
  logic              csr_illegal_o;
  logic [11:0]       wb_csraddr_i;
  logic [XLEN-1:0]   wb_csrdata_i;
  logic              wb_csrwe_i;
  logic [11:0]       heap_csraddr_i;
  logic [HEAP_W-1:0] heap_csrdata_i;
  logic              heap_csrwe_i;
  logic              trap_i;
  logic [XLEN-1:0]   trap_epc_i;
  logic [XLEN-1:0]   trap_cause_i;
  logic              mret_i;
  logic              retire_i;
  logic [XLEN-1:0]   mtvec_o, mepc_o, heap_base_o, heap_limit_o;
  logic              mie_o, heap_ovf_o;

  csr_file #(.XLEN(XLEN), .HEAP_W(HEAP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_raddr_i(csr_raddr_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .wb_csraddr_i(wb_csraddr_i), .wb_csrdata_i(wb_csrdata_i), .wb_csrwe_i(wb_csrwe_i),
    .heap_csraddr_i(heap_csraddr_i), .heap_csrdata_i(heap_csrdata_i), .heap_csrwe_i(heap_csrwe_i),
    .trap_i(trap_i), .trap_epc_i(trap_epc_i), .trap_cause_i(trap_cause_i),
    .mret_i(mret_i), .retire_i(retire_i),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o),
    .heap_base_o(heap_base_o), .heap_limit_o(heap_limit_o), .heap_ovf_o(heap_ovf_o)
  );

  always #5 clk = ~clk;

  localparam int S_RDATA = 0, S_ILL = 1, S_MTVEC = 2, S_MEPC = 3, S_MIE = 4,
                 S_BASE = 5, S_LIMIT = 6, S_OVF = 7;

  typedef struct {
    string           name;
    int              sel;
    logic [XLEN-1:0] exp;
  } item_t;

  item_t sb_q[$];
  logic  chk_valid = 1'b0;
  int    n_tests = 0;
  int    n_fail  = 0;

  always @(negedge clk) begin
    if (chk_valid) begin
      while (sb_q.size() > 0) begin
        item_t it;
        logic [XLEN-1:0] act;
        it = sb_q.pop_front();
        case (it.sel)
          S_RDATA: act = csr_rdata_o;
          S_ILL:   act = XLEN'(csr_illegal_o);
          S_MTVEC: act = mtvec_o;
          S_MEPC:  act = mepc_o;
          S_MIE:   act = XLEN'(mie_o);
          S_BASE:  act = heap_base_o;
          S_LIMIT: act = heap_limit_o;
          default: act = XLEN'(heap_ovf_o);
        endcase
        n_tests++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    chk_valid      = 1'b0;
    wb_csrwe_i     = 1'b0;
    heap_csrwe_i   = 1'b0;
    trap_i         = 1'b0;
    mret_i         = 1'b0;
  endtask

  task automatic exp_out(input string n, input int sel, input logic [XLEN-1:0] e);
    item_t it;
    it.name = n; it.sel = sel; it.exp = e;
    sb_q.push_back(it);
    chk_valid = 1'b1;
  endtask

  task automatic exp_rd(input string n, input logic [11:0] a, input logic [XLEN-1:0] e);
    csr_raddr_i = a;
    exp_out(n, S_RDATA, e);
  endtask

  task automatic wb_wr(input logic [11:0] a, input logic [XLEN-1:0] d);
    wb_csraddr_i = a; wb_csrdata_i = d; wb_csrwe_i = 1'b1;
  endtask

  task automatic heap_wr(input logic [11:0] a, input logic [HEAP_W-1:0] d);
    heap_csraddr_i = a; heap_csrdata_i = d; heap_csrwe_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; csr_raddr_i = '0;
    wb_csraddr_i = '0; wb_csrdata_i = '0; wb_csrwe_i = 1'b0;
    heap_csraddr_i = '0; heap_csrdata_i = '0; heap_csrwe_i = 1'b0;
    trap_i = 1'b0; trap_epc_i = '0; trap_cause_i = '0; mret_i = 1'b0; retire_i = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    exp_rd("rst_mcycle", 12'hB00, 0);
    exp_out("rst_mtvec", S_MTVEC, 0);
    exp_out("rst_mepc", S_MEPC, 0);
    exp_out("rst_mie", S_MIE, 0);
    exp_out("rst_base", S_BASE, 0);
    exp_out("rst_limit", S_LIMIT, 0);
    exp_out("rst_ovf", S_OVF, 0);
    tick();
    exp_rd("rst_mstatus", 12'h300, 0); tick();
    exp_rd("rst_heap_base", 12'h7C0, 0); tick();
    tick(); tick();
    exp_rd("mcycle_5", 12'hB00, 5);
    tick();
    exp_rd("illegal_rdata", 12'h123, 0);
    exp_out("illegal_flag", S_ILL, 1);
    tick();
    exp_rd("legal_flag_rd", 12'h340, 0);
    exp_out("legal_flag", S_ILL, 0);
    tick();

    wb_wr(12'h305, 64'h8000_0003); tick();
    exp_out("mtvec_mask", S_MTVEC, 64'h8000_0000);
    exp_rd("mtvec_rd", 12'h305, 64'h8000_0000);
    wb_wr(12'h341, 64'h1001); tick();
    exp_out("mepc_mask", S_MEPC, 64'h1000);
    wb_wr(12'h340, 64'hDEAD_BEEF_CAFE_F00D); tick();
    exp_rd("mscratch", 12'h340, 64'hDEAD_BEEF_CAFE_F00D);
    wb_wr(12'h123, 64'h55); tick();
    exp_rd("illegal_wr_drop", 12'h123, 0);
    tick();

    wb_wr(12'h7C1, 64'h10); heap_wr(12'h7C1, 32'h20); tick();
    exp_rd("wb_over_heap", 12'h7C1, 64'h10);
    exp_out("ovf_after_top", S_OVF, 1);
    heap_wr(12'h7C2, 32'h40); tick();
    exp_out("heap_limit", S_LIMIT, 64'h40);
    exp_out("ovf_sticky_heap", S_OVF, 1);
    heap_wr(12'h7C0, 32'hFFFF_FFFF); tick();
    exp_out("heap_zext", S_BASE, 64'h0000_0000_FFFF_FFFF);

    wb_wr(12'h300, 64'h8); tick();
    exp_out("mie_set", S_MIE, 1);
    exp_rd("mstatus_08", 12'h300, 64'h08);
    trap_i = 1'b1; trap_epc_i = 64'h2004; trap_cause_i = 64'hB;
    wb_wr(12'h341, 64'h5000); tick();
    exp_out("trap_mepc", S_MEPC, 64'h2004);
    exp_out("trap_mie", S_MIE, 0);
    exp_rd("trap_mcause", 12'h342, 64'hB);
    tick();
    exp_rd("trap_mpie", 12'h300, 64'h80);
    mret_i = 1'b1; tick();
    exp_out("mret_mie", S_MIE, 1);
    exp_rd("mret_mstatus", 12'h300, 64'h88);
    trap_i = 1'b1; mret_i = 1'b1; trap_epc_i = 64'h3001; trap_cause_i = 64'h7; tick();
    exp_out("trap_mret_mepc", S_MEPC, 64'h3000);
    exp_out("trap_mret_mie", S_MIE, 0);
    exp_rd("trap_mret_mstatus", 12'h300, 64'h80);
    tick();

    wb_wr(12'hB00, '1); tick();
    exp_rd("mcycle_written", 12'hB00, '1); tick();
    exp_rd("mcycle_wrap", 12'hB00, 0); tick();
    retire_i = 1'b1; tick(); tick(); tick();
    retire_i = 1'b0; tick(); tick();
    exp_rd("minstret_3", 12'hB02, 3); tick();
    retire_i = 1'b1; wb_wr(12'hB02, 64'h7); tick();
    retire_i = 1'b0;
    exp_rd("minstret_wr_wins", 12'hB02, 7); tick();

    wb_wr(12'h7C2, 64'h100); tick();
    exp_out("ovf_limit_no_clear", S_OVF, 1);
    wb_wr(12'h7C1, 64'h10); tick();
    exp_out("ovf_wb_clear", S_OVF, 0);
    heap_wr(12'h7C1, 32'h180); tick();
    exp_out("ovf_set", S_OVF, 1);
    heap_wr(12'h7C1, 32'h80); tick();
    exp_out("ovf_heap_no_clear", S_OVF, 1);
    exp_rd("heap_top_80", 12'h7C1, 64'h80);
    wb_wr(12'h7C1, 64'h80); tick();
    exp_out("ovf_clear", S_OVF, 0);
    heap_wr(12'h7C1, 32'h180); tick();

    wb_wr(12'h305, 64'h4444);
    #2 rst_n = 1'b0;
    exp_out("arst_mtvec", S_MTVEC, 0);
    exp_out("arst_mepc", S_MEPC, 0);
    exp_out("arst_mie", S_MIE, 0);
    exp_out("arst_base", S_BASE, 0);
    exp_out("arst_limit", S_LIMIT, 0);
    exp_out("arst_ovf", S_OVF, 0);
    tick();
    rst_n = 1'b1;
    exp_out("arst_wr_dropped", S_MTVEC, 0);
    exp_rd("arst_heap_top", 12'h7C1, 0);
    tick();

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    while (sb_q.size() > 0) begin
      item_t it;
      it = sb_q.pop_front();
      n_tests++; n_fail++;
      $display("FAIL %s: got unchecked expected checked", it.name);
    end

    n_tests++;
    if (mtvec_o !== 64'h0) begin
      n_fail++;
      $display("FAIL final_mtvec: got 0x%0h expected 0x0", mtvec_o);
    end
    n_tests++;
    if (mepc_o !== 64'h0) begin
      n_fail++;
      $display("FAIL final_mepc: got 0x%0h expected 0x0", mepc_o);
    end
    n_tests++;
    if (mie_o !== 1'b0) begin
      n_fail++;
      $display("FAIL final_mie: got %0b expected 0", mie_o);
    end
    n_tests++;
    if (heap_limit_o !== 64'h0) begin
      n_fail++;
      $display("FAIL final_limit: got 0x%0h expected 0x0", heap_limit_o);
    end
    n_tests++;
    if (heap_ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL final_ovf: got %0b expected 0", heap_ovf_o);
    end
    csr_raddr_i = 12'h7C1;
    #1;
    n_tests++;
    if (csr_rdata_o !== 64'h0) begin
      n_fail++;
      $display("FAIL final_heap_top: got 0x%0h expected 0x0", csr_rdata_o);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
Machine-mode CSR storage. Produces the CSR read data that decode hands to the forwarding stage. It is the write/commit end of the CSR path:
- accepts writeback-stage CSR writes;
- accepts heap-unit CSR updates;
- accepts trap entry and mret from the commit logic;
- runs the mcycle/minstret counters.

Reads are combinational from architectural state only. In-flight values are supplied by forwarding, not by this block.

Parameters:
XLEN, 64, datapath width of every CSR and data port
HEAP_W, 32, width of heap-unit data port; zero-extended to XLEN on write

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
csr_raddr_i  in  12  decode read address
csr_rdata_o  out  XLEN  read data, combinational
csr_illegal_o  out  1  read address not implemented, combinational
wb_csraddr_i  in  12  writeback CSR address
wb_csrdata_i  in  XLEN  writeback CSR data
wb_csrwe_i  in  1  writeback CSR write enable
heap_csraddr_i  in  12  heap-unit CSR address
heap_csrdata_i  in  HEAP_W  heap-unit CSR data
heap_csrwe_i  in  1  heap-unit CSR write enable
trap_i  in  1  trap entry strobe, one cycle
trap_epc_i  in  XLEN  PC of trapping instruction
trap_cause_i  in  XLEN  mcause value
mret_i  in  1  mret commit strobe, one cycle
retire_i  in  1  one instruction retired this cycle
mtvec_o  out  XLEN  current mtvec
mepc_o  out  XLEN  current mepc
mie_o  out  1  mstatus.MIE
heap_base_o  out  XLEN  current heap_base
heap_limit_o  out  XLEN  current heap_limit
heap_ovf_o  out  1  sticky heap overflow flag

Behaviour:
Address map; any other address reads 0 with csr_illegal_o=1, and writes to it are dropped:
- 0x300 mstatus: only bit 3 (MIE) and bit 7 (MPIE) are stored; all other bits read 0.
- 0x305 mtvec: bits [1:0] forced 0 on write.
- 0x340 mscratch.
- 0x341 mepc: bit 0 forced 0 on write.
- 0x342 mcause.
- 0xB00 mcycle.
- 0xB02 minstret.
- 0x7C0 heap_base, 0x7C1 heap_top, 0x7C2 heap_limit.

Reset (rst_n low, asynchronous): every CSR clears to 0, so mtvec_o=0, mepc_o=0, mie_o=0, heap_base_o=0, heap_limit_o=0, heap_ovf_o=0. Reset asserted mid-operation discards any same-edge write.

Reads: csr_rdata_o reflects state after the last rising edge. A write is visible on csr_rdata_o the cycle after its edge; there is no internal bypass.

Write latency: one edge for all write sources.

Per-CSR write priority, highest first; lower sources to the same CSR on the same edge are dropped:
1. trap_i
2. mret_i
3. wb write
4. heap write
5. counter increment

Writes to different CSRs on the same edge all take effect.

trap_i:
- mepc <= trap_epc_i with bit 0 cleared.
- mcause <= trap_cause_i.
- MPIE <= MIE, MIE <= 0.
- trap_i together with mret_i: trap wins, mret is ignored.

mret_i: MIE <= MPIE, MPIE <= 1.

Heap write: data zero-extended from HEAP_W to XLEN. The heap port may target any map entry.

mcycle:
- Increments by 1 every cycle unless written that edge; a written value replaces the increment.
- Wraps from 2^XLEN-1 to 0.

minstret:
- Increments by 1 when retire_i=1 and it is not written that edge.
- Same wrap rule as mcycle.

heap_ovf_o:
- Set on the edge after any write that leaves heap_top > heap_limit (unsigned). The compare uses post-write values of both registers.
- Cleared only by a wb write to 0x7C1 whose result satisfies heap_top <= heap_limit.
- A heap-port write never clears it.

Test Plan:
1. Reset, then read 0x300, 0xB00, 0x7C0 -> 0, 0, 0; then mcycle after 5 cycles -> 5; read 0x123 -> rdata 0, illegal=1.
2. wb write 0x305 data 0x8000_0003 -> next cycle mtvec_o = 0x8000_0000; wb write 0x341 data 0x1001 -> mepc_o = 0x1000.
3. wb write 0x7C1=0x10 and heap write 0x7C1=0x20 on same edge -> heap_top reads 0x10; heap write 0x7C2=0x40 with no wb conflict -> heap_limit_o = 0x40.
4. MIE=1, trap_i with epc 0x2004, cause 0xB, and simultaneous wb write to 0x341 = 0x5000 -> mepc 0x2004, mcause 0xB, mie_o 0, MPIE 1; next mret_i -> mie_o 1, mstatus reads 0x88.
5. wb write mcycle = 2^XLEN-1 -> next cycle reads 0; minstret with retire_i high 3 cycles, low 2 -> 3; retire_i during a wb write of 7 to minstret -> 7.
6. heap_limit=0x100, heap write heap_top=0x180 -> heap_ovf_o=1 next cycle; heap write heap_top=0x80 -> remains 1; wb write heap_top=0x80 -> 0. Asserting rst_n low mid-sequence -> all outputs 0 immediately.
